// File: rtl/wishbone_master_if.sv
// Wishbone B3 master/slave bus signals.
// The _o/_i suffixes are named from the master's side.
interface wishbone_master_if;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic [3:0]  sel_o;
   logic [2:0]  cti_o;
   logic [1:0]  bte_o;
   logic        ack_i;
   logic        err_i;
   logic        rty_i;

   modport master (
      output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, cti_o, bte_o,
      input  dat_i, ack_i, err_i, rty_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, cti_o, bte_o,
      output dat_i, ack_i, err_i, rty_i
   );
endinterface

// File: rtl/wishbone_master.sv
// Wishbone B3 master: converts a command/write-data stream into single or
// incrementing-burst cycles, returning read beats and a completion status.
module wishbone_master #(
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              reset_i,
   wishbone_master_if.master wb,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [31:0]       cmd_adr_i,
   input  logic [3:0]        cmd_sel_i,
   input  logic [3:0]        cmd_len_i,
   input  logic [31:0]       wr_dat_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   output logic [31:0]       rd_dat_o,
   output logic              rd_valid_o,
   output logic              done_o,
   output logic [1:0]        status_o,
   output logic              busy_o
);
   typedef enum logic [1:0] {IDLE, LOAD, STROBE, DONE} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
   localparam logic [1:0] STATUS_OK  = 2'b00;
   localparam logic [1:0] STATUS_ERR = 2'b01;
   localparam logic [1:0] STATUS_RTY = 2'b10;
   localparam logic [1:0] STATUS_TMO = 2'b11;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   state_t      state_reg;
   logic        cyc_reg;
   logic        stb_reg;
   logic        we_reg;
   logic        burst_reg;
   logic [31:0] adr_reg;
   logic [31:0] dat_reg;
   logic [3:0]  sel_reg;
   logic [2:0]  cti_reg;
   logic [3:0]  cnt_reg;
   logic [7:0]  tmo_reg;
   logic [31:0] rd_dat_reg;
   logic        rd_valid_reg;
   logic        done_reg;
   logic [1:0]  status_reg;
   logic        busy_reg;

   logic        cmd_accept;
   logic        ack_ok;
   logic        last_beat;
   logic [3:0]  cnt_next;

   function automatic logic [2:0] cti_for(input logic burst, input logic [3:0] remaining);
      if (!burst) begin
         return CTI_CLASSIC;
      end
      return (remaining == 4'd0) ? CTI_END : CTI_INCR;
   endfunction

   // Ready strobes are gated by reset so they read 0 while reset is held.
   assign cmd_ready_o = reset_i && (state_reg == IDLE);
   assign cmd_accept  = cmd_ready_o && cmd_valid_i;
   assign ack_ok      = (state_reg == STROBE) && wb.ack_i && !wb.err_i && !wb.rty_i;
   assign last_beat   = (cnt_reg == 4'd0);
   assign cnt_next    = cnt_reg - 4'd1;

   assign wr_ready_o = reset_i && wr_valid_i &&
                       ((cmd_accept && cmd_we_i) ||
                        (state_reg == LOAD) ||
                        (ack_ok && we_reg && !last_beat));

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_reg    <= IDLE;
         cyc_reg      <= 1'b0;
         stb_reg      <= 1'b0;
         we_reg       <= 1'b0;
         burst_reg    <= 1'b0;
         adr_reg      <= 32'd0;
         dat_reg      <= 32'd0;
         sel_reg      <= 4'd0;
         cti_reg      <= 3'd0;
         cnt_reg      <= 4'd0;
         tmo_reg      <= 8'd0;
         rd_dat_reg   <= 32'd0;
         rd_valid_reg <= 1'b0;
         done_reg     <= 1'b0;
         status_reg   <= 2'd0;
         busy_reg     <= 1'b0;
      end else begin
         rd_valid_reg <= 1'b0;
         done_reg     <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cmd_valid_i) begin
                  we_reg    <= cmd_we_i;
                  adr_reg   <= {cmd_adr_i[31:2], 2'b00};
                  sel_reg   <= cmd_sel_i;
                  cnt_reg   <= cmd_len_i;
                  burst_reg <= (cmd_len_i != 4'd0);
                  cti_reg   <= cti_for(cmd_len_i != 4'd0, cmd_len_i);
                  tmo_reg   <= 8'd0;
                  cyc_reg   <= 1'b1;
                  busy_reg  <= 1'b1;
                  if (!cmd_we_i) begin
                     stb_reg   <= 1'b1;
                     state_reg <= STROBE;
                  end else if (wr_valid_i) begin
                     dat_reg   <= wr_dat_i;
                     stb_reg   <= 1'b1;
                     state_reg <= STROBE;
                  end else begin
                     stb_reg   <= 1'b0;
                     state_reg <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (wr_valid_i) begin
                  dat_reg   <= wr_dat_i;
                  stb_reg   <= 1'b1;
                  tmo_reg   <= 8'd0;
                  state_reg <= STROBE;
               end
            end

            STROBE: begin
               if (wb.err_i) begin
                  cyc_reg    <= 1'b0;
                  stb_reg    <= 1'b0;
                  done_reg   <= 1'b1;
                  status_reg <= STATUS_ERR;
                  state_reg  <= DONE;
               end else if (wb.rty_i) begin
                  cyc_reg    <= 1'b0;
                  stb_reg    <= 1'b0;
                  done_reg   <= 1'b1;
                  status_reg <= STATUS_RTY;
                  state_reg  <= DONE;
               end else if (wb.ack_i) begin
                  adr_reg <= adr_reg + 32'd4;
                  cnt_reg <= cnt_next;
                  tmo_reg <= 8'd0;
                  cti_reg <= cti_for(burst_reg, cnt_next);
                  if (!we_reg) begin
                     rd_dat_reg   <= wb.dat_i;
                     rd_valid_reg <= 1'b1;
                  end
                  if (last_beat) begin
                     cyc_reg    <= 1'b0;
                     stb_reg    <= 1'b0;
                     done_reg   <= 1'b1;
                     status_reg <= STATUS_OK;
                     state_reg  <= DONE;
                  end else if (we_reg) begin
                     // Without fresh data the strobe pauses in LOAD but cyc stays owned.
                     if (wr_valid_i) begin
                        dat_reg <= wr_dat_i;
                     end else begin
                        stb_reg   <= 1'b0;
                        state_reg <= LOAD;
                     end
                  end
               end else if (tmo_reg == TIMEOUT_LAST) begin
                  cyc_reg    <= 1'b0;
                  stb_reg    <= 1'b0;
                  done_reg   <= 1'b1;
                  status_reg <= STATUS_TMO;
                  state_reg  <= DONE;
               end else begin
                  tmo_reg <= tmo_reg + 8'd1;
               end
            end

            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign wb.cyc_o = cyc_reg;
   assign wb.stb_o = stb_reg;
   assign wb.we_o  = we_reg;
   assign wb.adr_o = adr_reg;
   assign wb.dat_o = dat_reg;
   assign wb.sel_o = sel_reg;
   assign wb.cti_o = cti_reg;
   assign wb.bte_o = 2'b00;

   assign rd_dat_o   = rd_dat_reg;
   assign rd_valid_o = rd_valid_reg;
   assign done_o     = done_reg;
   assign status_o   = status_reg;
   assign busy_o     = busy_reg;
endmodule

// File: tb/tb_wishbone_master.sv
// Bench for wishbone_master: directed vector table, hand-written reset/latency
// sequences and random commands against a per-beat behavioural model.
`timescale 1ns/1ps
module tb_wishbone_master;
   localparam int TO = 4;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      int          len;
      int          abort_beat;   // -1: no abort
      int          abort_kind;   // 1 err, 2 rty, 3 slave never answers
      logic        abort_ack;
      int          delay;        // -1: random 0..2 unacked strobe cycles per beat
      int          gap;          // -1: random 0..2 idle cycles before each write word
      int          gap_word;     // -1: gap applies to every word
      int          exp_status;
      int          exp_rd;
      int          exp_wr;
      int          exp_load;     // -1: don't care
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr;
   logic [3:0]  cmd_sel, cmd_len;
   logic [31:0] wr_dat;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_dat;
   logic        rd_valid, done;
   logic [1:0]  status;
   logic        busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_cmd    = 0;
   vec_t vecs[11];
   vec_t rv;

   wishbone_master_if wb();

   wishbone_master #(.TIMEOUT(TO)) dut (
      .clk_i(clk), .reset_i(reset_n), .wb(wb),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_len_i(cmd_len),
      .wr_dat_i(wr_dat), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
      .rd_dat_o(rd_dat), .rd_valid_o(rd_valid), .done_o(done),
      .status_o(status), .busy_o(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] beat_adr(input logic [31:0] a, input int i);
      return {a[31:2], 2'b00} + 32'(4 * i);
   endfunction

   function automatic logic [2:0] beat_cti(input int len, input int i);
      if (len == 0) return 3'b000;
      if (i == len) return 3'b111;
      return 3'b010;
   endfunction

   function automatic logic any_output();
      return |{wb.cyc_o, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o, wb.sel_o, wb.cti_o,
               wb.bte_o, cmd_ready, wr_ready, rd_dat, rd_valid, done, status, busy};
   endfunction

   // Entered and left at posedge+1 of a cycle in which the DUT is idle.
   task automatic run_cmd(input vec_t v);
      logic [31:0] wdata[16];
      logic [31:0] rdata[16];
      int   gaps[16];
      int   delays[16];
      int   wi = 0, gcnt = 0, b = 0, wcnt = 0, nrd = 0, nwr = 0;
      int   load_cycles = 0, accept_cycle = -1, exp_acked;
      logic got_done = 1'b0, term_ack, stb_seen;

      exp_acked = (v.abort_beat < 0) ? v.len + 1 : v.abort_beat;
      for (int i = 0; i < 16; i++) begin
         wdata[i]  = $urandom;
         rdata[i]  = $urandom;
         gaps[i]   = (v.gap < 0) ? int'($urandom_range(0, 2)) :
                     ((v.gap_word < 0 || v.gap_word == i) ? v.gap : 0);
         delays[i] = (v.delay < 0) ? int'($urandom_range(0, 2)) : v.delay;
      end

      cmd_valid = 1'b1;
      cmd_we    = v.we;
      cmd_adr   = v.adr;
      cmd_sel   = v.sel;
      cmd_len   = 4'(v.len);
      for (int cy = 0; cy < 400 && !got_done; cy++) begin
         term_ack = 1'b0;
         stb_seen = 1'b0;
         if (v.we) begin
            wr_valid = 1'b0;
            wr_dat   = $urandom;
            if (wi <= v.len) begin
               wr_valid = (gcnt >= gaps[wi]);
               wr_dat   = wdata[wi];
            end
         end else begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_dat   = $urandom;
         end

         wb.ack_i = 1'b0;
         wb.err_i = 1'b0;
         wb.rty_i = 1'b0;
         wb.dat_i = $urandom;
         if (wb.cyc_o && wb.stb_o) begin
            stb_seen = 1'b1;
            if (b > v.len) begin
               check("beat_overrun", 32'(b), 32'(v.len));
            end else begin
               if (wcnt == 0) begin
                  check("adr", wb.adr_o, beat_adr(v.adr, b));
                  check("cti", 32'(wb.cti_o), 32'(beat_cti(v.len, b)));
                  check("we", 32'(wb.we_o), 32'(v.we));
                  check("sel", 32'(wb.sel_o), 32'(v.sel));
                  if (v.we) check("dat_o", wb.dat_o, wdata[b]);
               end
               if (wcnt >= delays[b]) begin
                  if (b == v.abort_beat) begin
                     if (v.abort_kind == 1) begin
                        wb.err_i = 1'b1;
                        wb.rty_i = 1'($urandom_range(0, 1));
                        wb.ack_i = v.abort_ack;
                     end else if (v.abort_kind == 2) begin
                        wb.rty_i = 1'b1;
                        wb.ack_i = v.abort_ack;
                     end
                  end else begin
                     wb.ack_i = 1'b1;
                     wb.dat_i = rdata[b];
                     term_ack = 1'b1;
                  end
               end
            end
         end else if (busy && !done) begin
            load_cycles++;
            check("cyc_in_load", 32'(wb.cyc_o), 32'd1);
         end

         #1;
         if (cmd_valid && cmd_ready) accept_cycle = cy;
         if (wr_ready) begin
            check("wr_ready_needs_valid", 32'(wr_valid), 32'd1);
            nwr++;
            wi++;
            gcnt = 0;
         end else begin
            gcnt++;
         end
         if (rd_valid) begin
            if (nrd <= v.len) check("rd_dat", rd_dat, rdata[nrd]);
            nrd++;
         end
         if (done) begin
            got_done = 1'b1;
            check("status", 32'(status), 32'(v.exp_status));
            check("cyc_at_done", 32'(wb.cyc_o), 32'd0);
            check("ready_at_done", 32'(cmd_ready), 32'd0);
            if (v.abort_beat >= 0 && v.abort_kind == 3) check("timeout_cycles", 32'(wcnt), 32'(TO));
         end

         @(posedge clk);
         #1;
         if (accept_cycle >= 0) cmd_valid = 1'b0;
         if (term_ack) begin
            b++;
            wcnt = 0;
         end else if (stb_seen) begin
            wcnt++;
         end
      end

      wr_valid  = 1'b0;
      cmd_valid = 1'b0;
      wb.ack_i  = 1'b0;
      wb.err_i  = 1'b0;
      wb.rty_i  = 1'b0;
      if (!got_done) check("done_seen", 32'd0, 32'd1);
      check("accept_cycle", 32'(accept_cycle), 32'd0);
      check("beats_acked", 32'(b), 32'(exp_acked));
      check("rd_pulses", 32'(nrd), 32'(v.exp_rd));
      check("wr_pulses", 32'(nwr), 32'(v.exp_wr));
      if (v.exp_load >= 0) check("load_cycles", 32'(load_cycles), 32'(v.exp_load));
      $display("cmd %0d: we=%0b adr=%08h len=%0d status=%0d rd=%0d wr=%0d load=%0d",
               n_cmd, v.we, v.adr, v.len, v.exp_status, nrd, nwr, load_cycles);
      n_cmd++;
   endtask

   initial begin
      // we, adr, sel, len, abort_beat, abort_kind, abort_ack, delay, gap, gap_word,
      // exp_status, exp_rd, exp_wr, exp_load
      vecs[0]  = '{1'b0, 32'h0000_0008, 4'hF, 0,  -1, 0, 1'b0, 1, 0, -1, 0, 1,  0, 0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 4'hF, 3,  -1, 0, 1'b0, 0, 0, -1, 0, 0,  4, 0};
      vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 2,  -1, 0, 1'b0, 0, 2,  1, 0, 0,  3, 2};
      vecs[3]  = '{1'b0, 32'hFFFF_FFF0, 4'hF, 15, -1, 0, 1'b0, 0, 0, -1, 0, 16, 0, 0};
      vecs[4]  = '{1'b0, 32'h0000_0100, 4'hF, 3,   1, 1, 1'b1, 0, 0, -1, 1, 1,  0, 0};
      vecs[5]  = '{1'b0, 32'h0000_0200, 4'hF, 0,   0, 3, 1'b0, 0, 0, -1, 3, 0,  0, 0};
      vecs[6]  = '{1'b1, 32'h0000_0300, 4'hC, 2,   2, 2, 1'b0, 1, 0, -1, 2, 0,  3, 0};
      vecs[7]  = '{1'b1, 32'h0000_0040, 4'h1, 0,  -1, 0, 1'b0, 0, 2, -1, 0, 0,  1, 2};
      vecs[8]  = '{1'b1, 32'h0000_0080, 4'hF, 1,   0, 1, 1'b1, 0, 0, -1, 1, 0,  1, 0};
      vecs[9]  = '{1'b0, 32'h0000_0600, 4'h3, 7,   5, 3, 1'b0, 0, 0, -1, 3, 5,  0, 0};
      vecs[10] = '{1'b1, 32'h0000_1237, 4'h6, 1,  -1, 0, 1'b0, 2, 0, -1, 0, 0,  2, 0};

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = 32'd0;
      cmd_sel   = 4'd0;
      cmd_len   = 4'd0;
      wr_dat    = 32'd0;
      wr_valid  = 1'b0;
      wb.dat_i  = 32'd0;
      wb.ack_i  = 1'b0;
      wb.err_i  = 1'b0;
      wb.rty_i  = 1'b0;

      // Held reset with a pending write command: everything stays at zero.
      repeat (3) begin
         @(posedge clk);
         #1;
         cmd_valid = 1'b1;
         cmd_we    = 1'b1;
         cmd_len   = 4'd3;
         wr_valid  = 1'b1;
         #1;
         check("reset_outputs_zero", 32'(any_output()), 32'd0);
      end
      reset_n   = 1'b1;
      cmd_valid = 1'b0;
      wr_valid  = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) run_cmd(vecs[i]);

      // Reset in the middle of an 8-beat read burst.
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h0000_0500;
      cmd_sel   = 4'hF;
      cmd_len   = 4'd7;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wb.ack_i  = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("midburst_busy", 32'(busy), 32'd1);
      check("midburst_stb", 32'(wb.stb_o), 32'd1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      wb.ack_i = 1'b0;
      #1;
      check("midburst_reset_zero", 32'(any_output()), 32'd0);
      check("midburst_no_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      #1;
      check("after_reset_done", 32'(done), 32'd0);
      check("after_reset_ready", 32'(cmd_ready), 32'd1);
      check("after_reset_cyc", 32'(wb.cyc_o), 32'd0);
      @(posedge clk);
      #1;

      for (int n = 0; n < 40; n++) begin
         rv.we       = 1'($urandom_range(0, 1));
         rv.adr      = $urandom;
         rv.sel      = 4'($urandom_range(0, 15));
         rv.len      = int'($urandom_range(0, 15));
         rv.abort_ack = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            rv.abort_beat = int'($urandom_range(0, rv.len));
            rv.abort_kind = int'($urandom_range(1, 3));
         end else begin
            rv.abort_beat = -1;
            rv.abort_kind = 0;
         end
         rv.delay      = -1;
         rv.gap        = -1;
         rv.gap_word   = -1;
         rv.exp_load   = -1;
         rv.exp_status = (rv.abort_beat < 0) ? 0 : rv.abort_kind;
         rv.exp_rd     = rv.we ? 0 : ((rv.abort_beat < 0) ? rv.len + 1 : rv.abort_beat);
         rv.exp_wr     = !rv.we ? 0 : ((rv.abort_beat < 0) ? rv.len + 1 : rv.abort_beat + 1);
         run_cmd(rv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wishbone_master.md
# wishbone_master

Wishbone B3 bus master that turns a simple command/data stream into single or incrementing-burst Wishbone cycles. It is the initiator counterpart of the PCI-side register slave. It sits between a local controller (command sequencer, host bridge or test logic) and the shared Wishbone bus. The block handles write-data flow control, read-data return, burst sequencing, error/retry termination and an ack timeout.

## Interface
Parameters:
- TIMEOUT, 255: cycles of strobe without ack_i before abort (8-bit counter, 1..255).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- cyc_o, stb_o, we_o  out  1 each  Wishbone cycle, strobe, write-enable.
- adr_o  out  32  byte address; adr_o[1:0] always 00.
- dat_o  out  32  write data.
- dat_i  in  32  read data.
- sel_o  out  4  byte selects.
- cti_o  out  3  cycle type; bte_o  out  2  burst type, constant 00.
- ack_i, err_i, rty_i  in  1 each  slave termination.
- cmd_valid_i  in  1  command request; cmd_ready_o  out  1  command accepted when both high.
- cmd_we_i  in  1  1 = write; cmd_adr_i  in  32  start address; cmd_sel_i  in  4  byte selects for all beats.
- cmd_len_i  in  4  beats minus 1 (0 = single, 15 = 16 beats).
- wr_dat_i  in  32  write data; wr_valid_i  in  1  data present; wr_ready_o  out  1  data consumed this cycle.
- rd_dat_o  out  32  read beat data; rd_valid_o  out  1  one-cycle pulse per read beat.
- done_o  out  1  one-cycle pulse at command end; status_o  out  2  valid with done_o: 00 ok, 01 err, 10 rty, 11 timeout.
- busy_o  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, LOAD (cyc high, stb low, waiting for write data), STROBE (cyc and stb high), DONE.
- IDLE: cmd_ready_o=1. On accept, latch we, adr ({cmd_adr_i[31:2],00}), sel, and beat counter = cmd_len_i.
  - Read: go to STROBE.
  - Write with wr_valid_i=1: wr_ready_o=1, latch dat_o, go to STROBE.
  - Write with wr_valid_i=0: go to LOAD.
- LOAD: when wr_valid_i=1, wr_ready_o=1, latch dat_o, go to STROBE.
- cti_o:
  - cmd_len_i=0: 000.
  - Burst, all beats except the last: 010.
  - Last beat: 111.
  - The counter value of the current beat determines cti_o.
- STROBE on ack_i (no err_i/rty_i):
  - adr_o += 4 (32-bit wrap, no carry out); counter decrements.
  - Read: register dat_i into rd_dat_o; rd_valid_o=1 next cycle.
  - Last beat: go to DONE, status 00.
  - Else, write: if wr_valid_i=1, wr_ready_o=1, latch next dat_o, stay in STROBE; otherwise go to LOAD (stb drops, cyc held).
  - Else, read: stay in STROBE.
- Abort: err_i (priority over ack_i and rty_i) -> DONE with status 01; else rty_i -> DONE with status 10.
  - Timeout counter clears on entry to STROBE and on each ack_i; it increments each STROBE cycle without termination. Reaching TIMEOUT -> DONE with status 11.
  - On abort: no further wr_ready_o or rd_valid_o; remaining beats are dropped.
- DONE: cyc_o=stb_o=0, done_o=1, then IDLE.
- Reset: all outputs 0 (cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, cti_o, bte_o, cmd_ready_o, wr_ready_o, rd_dat_o, rd_valid_o, done_o, status_o, busy_o). State goes to IDLE. Reset mid-cycle drops cyc_o/stb_o on the next edge with no done_o.

## Timing
- Outputs come from registers, except cmd_ready_o and wr_ready_o, which are decoded from state and inputs.
- Read, single beat, slave acks 1 cycle after stb:
  - Accept at edge 0.
  - cyc/stb high in cycle 1; ack_i in cycle 2.
  - rd_valid_o and done_o in cycle 3; cyc_o low in cycle 3.
- Burst with continuous ack_i: one beat per cycle with stb_o unbroken; adr_o changes the cycle after each ack.
- Write data missing at an ack: exactly one-cycle minimum stb gap (LOAD), cti resumes with the same beat count.
- A command can be accepted no earlier than the cycle after DONE (minimum 1 idle cycle between cycles).

## Test plan
- Single read, cmd_adr_i=0x00000008, cmd_sel_i=F; slave acks after 1 cycle with 0xDEADBEEF. Required:
  - adr_o=0x8, cti_o=000.
  - rd_dat_o=0xDEADBEEF with one rd_valid_o pulse.
  - done_o with status 00.
- 4-beat write burst from 0x10, wr_valid_i always high, continuous ack. Required:
  - Addresses 0x10/0x14/0x18/0x1C; cti 010,010,010,111.
  - Four wr_ready_o pulses; stb never drops.
- 3-beat write with wr_valid_i low for 2 cycles before beat 2. Required:
  - stb_o low while in LOAD, cyc_o stays high.
  - Beat 2 carries the correct data; cti 010,010,111 per beat.
- 16-beat read (cmd_len_i=15) starting at 0xFFFFFFF0. Required:
  - adr_o wraps 0xFFFFFFFC -> 0x00000000.
  - 16 rd_valid_o pulses.
- err_i together with ack_i on beat 2 of a 4-beat read. Required:
  - Only one rd_valid_o.
  - done_o with status 01; cyc_o low next cycle.
- No ack for TIMEOUT=4 cycles. Required: done_o with status 11 after the 4th unacked strobe cycle.
- reset_i low mid-burst. Required: all outputs 0 next cycle, no done_o.
